// File: rtl/d_cache_pkg.sv
// Shared types and helpers for the 2-way write-back data cache.
package d_cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

  // Widest word the merge helper handles; callers zero-extend and slice back.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic int calc_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int index_w, input int data_w);
    return addr_w - index_w - calc_off_w(data_w);
  endfunction

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   byte_en
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < MAX_BE_W; b++) begin
      if (byte_en[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/d_cache_wb2_way.sv
// One cache way: tag/data storage with asynchronous read, valid/dirty bits cleared by reset.
module dc_way_array #(
  parameter int INDEX_W = 7,
  parameter int TAG_W   = 23,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] i_index,
  input  logic               i_we,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [DATA_W-1:0]  i_wr_data,
  input  logic               i_wr_dirty,
  output logic               o_valid,
  output logic               o_dirty,
  output logic [TAG_W-1:0]   o_tag,
  output logic [DATA_W-1:0]  o_data
);
  localparam int SETS = 2 ** INDEX_W;

  logic [SETS-1:0]   r_valid;
  logic [SETS-1:0]   r_dirty;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [DATA_W-1:0] r_data [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_we) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= i_wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_index]  <= i_wr_tag;
      r_data[i_index] <= i_wr_data;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_data  = r_data[i_index];

endmodule

// File: rtl/d_cache_wb2.sv
// 2-way set-associative write-back / write-allocate data cache with LRU and a req/ready memory port.
module d_cache_wb2 import d_cache_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   read_data,
  output logic                hit,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int OFF_W = calc_off_w(DATA_W);
  localparam int TAG_W = calc_tag_w(ADDR_W, INDEX_W, DATA_W);
  localparam int SETS  = 2 ** INDEX_W;

  state_t              r_state, w_state_next;
  logic                r_victim, r_replay;
  logic [SETS-1:0]     r_lru;
  logic [DATA_W-1:0]   r_read_data, r_mem_wdata;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_hit, r_mem_req, r_mem_we;

  logic [INDEX_W-1:0]  w_index;
  logic [TAG_W-1:0]    w_tag;
  logic [1:0]          w_way_valid, w_way_dirty, w_way_hit, w_we;
  logic [TAG_W-1:0]    w_way_tag  [2];
  logic [DATA_W-1:0]   w_way_data [2];
  logic                w_req, w_is_load, w_is_store, w_lookup_hit, w_hit_way;
  logic                w_victim, w_victim_dirty, w_wr_dirty;
  logic [DATA_W-1:0]   w_hit_data, w_merged, w_wr_data;
  logic [MAX_DATA_W-1:0] w_merged_full;
  logic                w_unused;

  assign w_index    = address[OFF_W +: INDEX_W];
  assign w_tag      = address[ADDR_W-1 -: TAG_W];
  assign w_req      = mem_read | mem_write;
  assign w_is_load  = mem_read;
  assign w_is_store = mem_write & ~mem_read;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      dc_way_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_index    (w_index),
        .i_we       (w_we[gi]),
        .i_wr_tag   (w_tag),
        .i_wr_data  (w_wr_data),
        .i_wr_dirty (w_wr_dirty),
        .o_valid    (w_way_valid[gi]),
        .o_dirty    (w_way_dirty[gi]),
        .o_tag      (w_way_tag[gi]),
        .o_data     (w_way_data[gi])
      );
      assign w_way_hit[gi] = w_way_valid[gi] & (w_way_tag[gi] == w_tag);
    end
  endgenerate

  assign w_lookup_hit = |w_way_hit;
  assign w_hit_way    = w_way_hit[1];
  assign w_hit_data   = w_way_data[w_hit_way];

  // Invalid ways are consumed first (way0 before way1); only a full set consults LRU.
  assign w_victim       = ~w_way_valid[0] ? 1'b0 : (~w_way_valid[1] ? 1'b1 : r_lru[w_index]);
  assign w_victim_dirty = w_way_valid[w_victim] & w_way_dirty[w_victim];

  assign w_merged_full = byte_merge(MAX_DATA_W'(w_hit_data), MAX_DATA_W'(write_data),
                                    MAX_BE_W'(byte_en));
  assign w_merged      = w_merged_full[DATA_W-1:0];
  assign w_unused      = ^{address[OFF_W-1:0], w_merged_full[MAX_DATA_W-1:DATA_W]};

  always_comb begin
    w_state_next = r_state;
    w_we         = 2'b00;
    w_wr_data    = w_merged;
    w_wr_dirty   = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_lookup_hit) begin
            if (w_is_store) w_we[w_hit_way] = 1'b1;
          end else begin
            w_state_next = w_victim_dirty ? WB : FILL;
          end
        end
      end
      WB:   if (mem_ready) w_state_next = FILL;
      FILL: begin
        if (mem_ready) begin
          w_state_next  = IDLE;
          w_we[r_victim] = 1'b1;
          w_wr_data     = mem_rdata;
          w_wr_dirty    = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data <= '0;
      r_hit       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_victim    <= 1'b0;
      r_replay    <= 1'b0;
      r_lru       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && w_lookup_hit) begin
            if (w_is_load) r_read_data <= w_hit_data;
            // The replay after a fill completes a missed access, so hit stays low.
            r_hit          <= ~r_replay;
            r_lru[w_index] <= ~w_hit_way;
            r_replay       <= 1'b0;
          end else if (w_req) begin
            r_hit     <= 1'b0;
            r_victim  <= w_victim;
            r_mem_req <= 1'b1;
            if (w_victim_dirty) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {w_way_tag[w_victim], w_index, {OFF_W{1'b0}}};
              r_mem_wdata <= w_way_data[w_victim];
            end else begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_index, {OFF_W{1'b0}}};
            end
          end
        end
        WB: begin
          if (mem_ready) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_index, {OFF_W{1'b0}}};
          end
        end
        FILL: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_replay  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign d_stall   = (r_state != IDLE) | (w_req & ~w_lookup_hit);
  assign read_data = r_read_data;
  assign hit       = r_hit;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
